// File: rtl/uart_tx_fifo_if.sv
// Byte stream from the UART control block into the transmitter FIFO.
interface uart_tx_fifo_if;
   logic       to_uart_valid;
   logic [7:0] to_uart_data;
   logic       to_uart_ready;

   modport master (
      output to_uart_valid,
      output to_uart_data,
      input  to_uart_ready
   );

   modport slave (
      input  to_uart_valid,
      input  to_uart_data,
      output to_uart_ready
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: 8N1 frames, or 8E1/8O1 with parity enabled.
// Back-to-back frames are contiguous; a reset aborts the frame and flushes the FIFO.
module uart_tx_fifo #(
   parameter int unsigned CLK_FREQ   = 50000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned FIFO_DEPTH = 32,
   parameter bit          PARITY_EN  = 1'b0,
   parameter bit          PARITY_ODD = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst,
   uart_tx_fifo_if.slave                 up_if,
   output logic                          uart_txd,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow_err
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int unsigned AW           = $clog2(FIFO_DEPTH);
   localparam int unsigned CW           = AW + 1;
   localparam int unsigned BW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   // FIFO storage and bookkeeping
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ready_q, ready_d;
   logic          ovf_q, ovf_d;
   logic          push, pop;
   logic [7:0]    head;

   // Serialiser
   state_e        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic          txd_q, txd_d;
   logic          busy_q, busy_d;
   logic          last_tick;

   // Write is qualified by the registered ready, so a same-cycle pop never frees a slot
   assign push      = up_if.to_uart_valid & ready_q;
   assign head      = mem_q[rd_ptr_q];
   assign last_tick = (baud_q == BW'(CLKS_PER_BIT - 1));

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      txd_d   = txd_q;
      pop     = 1'b0;

      case (state_q)
         S_IDLE: begin
            txd_d  = 1'b1;
            baud_d = '0;
            if (count_q != '0) begin
               pop     = 1'b1;
               shift_d = head;
               par_d   = (^head) ^ PARITY_ODD;
               txd_d   = 1'b0;
               state_d = S_START;
            end
         end

         S_START: begin
            if (last_tick) begin
               baud_d  = '0;
               bit_d   = '0;
               txd_d   = shift_q[0];
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         S_DATA: begin
            if (last_tick) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  if (PARITY_EN) begin
                     txd_d   = par_q;
                     state_d = S_PARITY;
                  end else begin
                     txd_d   = 1'b1;
                     state_d = S_STOP;
                  end
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shift_d = shift_q >> 1;
                  txd_d   = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         S_PARITY: begin
            if (last_tick) begin
               baud_d  = '0;
               txd_d   = 1'b1;
               state_d = S_STOP;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         S_STOP: begin
            if (last_tick) begin
               baud_d = '0;
               // Chain straight into the next start bit when more data is waiting
               if (count_q != '0) begin
                  pop     = 1'b1;
                  shift_d = head;
                  par_d   = (^head) ^ PARITY_ODD;
                  txd_d   = 1'b0;
                  state_d = S_START;
               end else begin
                  txd_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         default: begin
            txd_d   = 1'b1;
            baud_d  = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end
      ready_d = (count_d != CW'(FIFO_DEPTH));
      ovf_d   = ovf_q | (up_if.to_uart_valid & ~ready_q);
      busy_d  = (state_d != S_IDLE) || (count_d != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         txd_q    <= 1'b1;
         busy_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         txd_q    <= txd_d;
         busy_q   <= busy_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ready_q  <= ready_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers and count
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= up_if.to_uart_data;
      end
   end

   assign up_if.to_uart_ready = ready_q;
   assign uart_txd            = txd_q;
   assign tx_busy             = busy_q;
   assign fifo_level          = count_q;
   assign overflow_err        = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances (plain 32-deep, 4-deep, even and odd parity),
// a frame decoder feeding a byte scoreboard, vector table plus hand-written corner cases.
module tb_uart_tx_fifo;

   localparam int unsigned CLK_FREQ = 1000000;
   localparam int unsigned BAUD     = 100000;
   localparam int unsigned CPB      = 10;
   localparam int          NDUT     = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   int unsigned cyc      = 0;

   logic       v_drv;
   logic [7:0] d_drv;
   int         sel;

   uart_tx_fifo_if if0 ();
   uart_tx_fifo_if if1 ();
   uart_tx_fifo_if if2 ();
   uart_tx_fifo_if if3 ();

   assign if0.to_uart_valid = v_drv && (sel == 0);
   assign if1.to_uart_valid = v_drv && (sel == 1);
   assign if2.to_uart_valid = v_drv && (sel == 2);
   assign if3.to_uart_valid = v_drv && (sel == 3);
   assign if0.to_uart_data  = d_drv;
   assign if1.to_uart_data  = d_drv;
   assign if2.to_uart_data  = d_drv;
   assign if3.to_uart_data  = d_drv;

   logic [NDUT-1:0] txd, busy, ovf, rdy;
   logic [5:0]      lvl0, lvl2, lvl3;
   logic [2:0]      lvl1;
   logic [5:0]      lvl [NDUT];

   assign rdy[0] = if0.to_uart_ready;
   assign rdy[1] = if1.to_uart_ready;
   assign rdy[2] = if2.to_uart_ready;
   assign rdy[3] = if3.to_uart_ready;
   assign lvl[0] = lvl0;
   assign lvl[1] = {3'b000, lvl1};
   assign lvl[2] = lvl2;
   assign lvl[3] = lvl3;

   uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(32), .PARITY_EN(1'b0), .PARITY_ODD(1'b0))
      u_dut0 (.clk(clk), .rst(rst), .up_if(if0), .uart_txd(txd[0]), .tx_busy(busy[0]),
              .fifo_level(lvl0), .overflow_err(ovf[0]));
   uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0))
      u_dut1 (.clk(clk), .rst(rst), .up_if(if1), .uart_txd(txd[1]), .tx_busy(busy[1]),
              .fifo_level(lvl1), .overflow_err(ovf[1]));
   uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(32), .PARITY_EN(1'b1), .PARITY_ODD(1'b0))
      u_dut2 (.clk(clk), .rst(rst), .up_if(if2), .uart_txd(txd[2]), .tx_busy(busy[2]),
              .fifo_level(lvl2), .overflow_err(ovf[2]));
   uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(32), .PARITY_EN(1'b1), .PARITY_ODD(1'b1))
      u_dut3 (.clk(clk), .rst(rst), .up_if(if3), .uart_txd(txd[3]), .tx_busy(busy[3]),
              .fifo_level(lvl3), .overflow_err(ovf[3]));

   typedef struct {
      int         dut;
      logic [7:0] data;
      logic       exp_ready;
      int         exp_level;
      logic       exp_ovf;
   } vec_t;

   vec_t        vecs [29];
   logic [7:0]  exp_q [NDUT][$];
   bit          mon_active [NDUT];
   int unsigned mcnt [NDUT];
   logic [10:0] fbits [NDUT];
   bit          glitch [NDUT];
   int          nframes [NDUT];
   int          contig [NDUT];
   int unsigned last_end [NDUT];
   logic        last_par [NDUT];

   function automatic bit par_en(input int g);
      return g >= 2;
   endfunction

   function automatic bit par_odd(input int g);
      return g == 3;
   endfunction

   function automatic int unsigned frame_len(input int g);
      return (10 + (par_en(g) ? 1 : 0)) * CPB;
   endfunction

   task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at cycle %0d", name, g, act, exp, cyc);
      end
   endtask

   task automatic note_fail(input string name, input int g);
      checks++;
      failures++;
      $display("FAIL %s dut%0d at cycle %0d", name, g, cyc);
   endtask

   task automatic check_frame(input int g);
      logic [7:0] got;
      logic [7:0] e;
      got = fbits[g][8:1];
      chk("frame_start_bit", g, 32'(fbits[g][0]), 32'd0);
      chk("frame_bit_width", g, 32'(glitch[g]), 32'd0);
      chk("frame_stop_bit", g, 32'(par_en(g) ? fbits[g][10] : fbits[g][9]), 32'd1);
      if (exp_q[g].size() == 0) begin
         note_fail("frame_unexpected", g);
      end else begin
         e = exp_q[g].pop_front();
         chk("frame_data", g, 32'(got), 32'(e));
         if (par_en(g)) begin
            last_par[g] = fbits[g][9];
            chk("frame_parity", g, 32'(fbits[g][9]), 32'((^e) ^ par_odd(g)));
         end
      end
   endtask

   // Decoder: samples every line at each falling edge and checks bit widths exactly
   task automatic mon_loop();
      int unsigned b;
      forever begin
         @(negedge clk);
         cyc++;
         for (int g = 0; g < NDUT; g++) begin
            if (rst) begin
               mon_active[g] = 1'b0;
            end else begin
               if (!mon_active[g] && txd[g] == 1'b0) begin
                  mon_active[g] = 1'b1;
                  mcnt[g]       = 0;
                  glitch[g]     = 1'b0;
                  fbits[g]      = '1;
                  if (nframes[g] > 0 && cyc == last_end[g] + 1) contig[g]++;
               end
               if (mon_active[g]) begin
                  b = mcnt[g] / CPB;
                  if (mcnt[g] % CPB == 0) fbits[g][b] = txd[g];
                  else if (fbits[g][b] !== txd[g]) glitch[g] = 1'b1;
                  mcnt[g]++;
                  if (mcnt[g] == frame_len(g)) begin
                     mon_active[g] = 1'b0;
                     last_end[g]   = cyc;
                     nframes[g]++;
                     check_frame(g);
                  end
               end
            end
         end
      end
   endtask

   task automatic wait_idle(input int g, input int maxn);
      int n;
      n = 0;
      while ((busy[g] || mon_active[g]) && n < maxn) begin
         @(negedge clk);
         n++;
      end
      if (busy[g] || mon_active[g]) note_fail("idle_timeout", g);
      @(negedge clk);
   endtask

   // One byte into an idle instance: start-bit latency and busy duration
   task automatic single_frame(input int g, input logic [7:0] b, input int exp_busy);
      int n;
      sel   = g;
      v_drv = 1'b1;
      d_drv = b;
      exp_q[g].push_back(b);
      @(posedge clk);
      @(negedge clk);
      v_drv = 1'b0;
      chk("latency_idle", g, 32'(txd[g]), 32'd1);
      n = 0;
      while (busy[g] && n < 1000) begin
         n++;
         @(negedge clk);
         if (n == 1) chk("latency_start", g, 32'(txd[g]), 32'd0);
      end
      chk("busy_cycles", g, 32'(n), 32'(exp_busy));
      @(negedge clk);
      chk("frame_seen", g, 32'(exp_q[g].size()), 32'd0);
   endtask

   task automatic apply_vectors(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         sel = vecs[i].dut;
         chk("vec_ready", sel, 32'(rdy[sel]), 32'(vecs[i].exp_ready));
         v_drv = 1'b1;
         d_drv = vecs[i].data;
         if (vecs[i].exp_ready) exp_q[sel].push_back(vecs[i].data);
         @(posedge clk);
         @(negedge clk);
         chk("vec_level", sel, 32'(lvl[sel]), 32'(vecs[i].exp_level));
         chk("vec_overflow", sel, 32'(ovf[sel]), 32'(vecs[i].exp_ovf));
      end
      v_drv = 1'b0;
   endtask

   initial begin
      int f0, c0, low;

      for (int i = 0; i < 23; i++) begin
         vecs[i] = '{0, 8'(i), 1'b1, (i == 0) ? 1 : i, 1'b0};
      end
      vecs[23] = '{1, 8'h10, 1'b1, 1, 1'b0};
      vecs[24] = '{1, 8'h11, 1'b1, 1, 1'b0};
      vecs[25] = '{1, 8'h12, 1'b1, 2, 1'b0};
      vecs[26] = '{1, 8'h13, 1'b1, 3, 1'b0};
      vecs[27] = '{1, 8'h14, 1'b1, 4, 1'b0};
      vecs[28] = '{1, 8'h15, 1'b0, 4, 1'b1};

      for (int g = 0; g < NDUT; g++) begin
         mon_active[g] = 1'b0;
         mcnt[g]       = 0;
         fbits[g]      = '1;
         glitch[g]     = 1'b0;
         nframes[g]    = 0;
         contig[g]     = 0;
         last_end[g]   = 0;
         last_par[g]   = 1'b0;
      end

      rst   = 1'b1;
      v_drv = 1'b0;
      d_drv = 8'h00;
      sel   = 0;
      fork
         mon_loop();
      join_none

      // Reset values
      repeat (3) @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
         chk("rst_txd", g, 32'(txd[g]), 32'd1);
         chk("rst_ready", g, 32'(rdy[g]), 32'd0);
         chk("rst_busy", g, 32'(busy[g]), 32'd0);
         chk("rst_level", g, 32'(lvl[g]), 32'd0);
         chk("rst_overflow", g, 32'(ovf[g]), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
         chk("ready_after_rst", g, 32'(rdy[g]), 32'd1);
      end

      // Single byte
      single_frame(0, 8'hA5, 101);
      chk("single_overflow", 0, 32'(ovf[0]), 32'd0);

      // Burst of 23 bytes, contiguous frames
      c0 = contig[0];
      f0 = nframes[0];
      apply_vectors(0, 22);
      wait_idle(0, 3000);
      chk("burst_frames", 0, 32'(nframes[0] - f0), 32'd23);
      chk("burst_contiguous", 0, 32'(contig[0] - c0), 32'd22);

      // Overflow on the 4-deep instance
      apply_vectors(23, 28);
      wait_idle(1, 1000);
      chk("ovf_frames", 1, 32'(nframes[1]), 32'd5);
      chk("ovf_sticky", 1, 32'(ovf[1]), 32'd1);
      chk("ovf_ready_back", 1, 32'(rdy[1]), 32'd1);

      // Parity even / odd
      single_frame(2, 8'h07, 111);
      chk("parity_even_bit", 2, 32'(last_par[2]), 32'd1);
      single_frame(3, 8'h07, 111);
      chk("parity_odd_bit", 3, 32'(last_par[3]), 32'd0);

      // Write landing on the last cycle of a stop bit
      c0    = contig[0];
      sel   = 0;
      v_drv = 1'b1;
      d_drv = 8'h33;
      exp_q[0].push_back(8'h33);
      @(posedge clk);
      @(negedge clk);
      v_drv = 1'b0;
      repeat (100) @(negedge clk);
      chk("stop_bit_high", 0, 32'(txd[0]), 32'd1);
      v_drv = 1'b1;
      d_drv = 8'h55;
      exp_q[0].push_back(8'h55);
      @(posedge clk);
      @(negedge clk);
      v_drv = 1'b0;
      chk("stop_end_idle_txd", 0, 32'(txd[0]), 32'd1);
      chk("stop_end_level", 0, 32'(lvl[0]), 32'd1);
      chk("stop_end_busy", 0, 32'(busy[0]), 32'd1);
      @(negedge clk);
      chk("stop_end_start", 0, 32'(txd[0]), 32'd0);
      wait_idle(0, 300);
      chk("stop_end_gap", 0, 32'(contig[0] - c0), 32'd0);

      // Reset during D3 of 0x3C with two more bytes queued
      sel   = 0;
      v_drv = 1'b1;
      d_drv = 8'h3C;
      @(posedge clk);
      @(negedge clk);
      d_drv = 8'hA1;
      @(posedge clk);
      @(negedge clk);
      d_drv = 8'hB2;
      @(posedge clk);
      @(negedge clk);
      v_drv = 1'b0;
      chk("midrst_queued", 0, 32'(lvl[0]), 32'd2);
      repeat (43) @(negedge clk);
      f0  = nframes[0];
      rst = 1'b1;
      #1;
      chk("midrst_txd", 0, 32'(txd[0]), 32'd1);
      chk("midrst_level", 0, 32'(lvl[0]), 32'd0);
      chk("midrst_ready", 0, 32'(rdy[0]), 32'd0);
      chk("midrst_busy", 0, 32'(busy[0]), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_ready_back", 0, 32'(rdy[0]), 32'd1);
      low = 0;
      repeat (300) begin
         @(negedge clk);
         if (txd[0] == 1'b0) low++;
      end
      chk("midrst_line_quiet", 0, 32'(low), 32'd0);
      chk("midrst_no_frames", 0, 32'(nframes[0] - f0), 32'd0);
      chk("midrst_idle_busy", 0, 32'(busy[0]), 32'd0);
      single_frame(0, 8'h81, 101);
      chk("midrst_one_frame", 0, 32'(nframes[0] - f0), 32'd1);

      for (int g = 0; g < NDUT; g++) begin
         chk("scoreboard_empty", g, 32'(exp_q[g].size()), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte transmitter directly downstream of the UART control block; consumes its to_uart_valid / to_uart_data / to_uart_ready stream and drives the serial TX pin.
- A small FIFO absorbs the control block's back-to-back bursts (one byte per clock while ready is high).
- Bytes are serialised as 8N1 frames, or 8E1/8O1 when parity is enabled.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate. CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be ≥2).
- FIFO_DEPTH, 32, FIFO entries; power of 2, ≥2.
- PARITY_EN, 0, 1 inserts a parity bit after D7.
- PARITY_ODD, 0, parity sense when enabled: 0 = even, 1 = odd.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- to_uart_valid  in  1  byte-present qualifier; level-sensitive.
- to_uart_data  in  8  byte to send.
- to_uart_ready  out  1  FIFO can accept a byte this cycle.
- uart_txd  out  1  serial output; idle high.
- tx_busy  out  1  FIFO non-empty or frame in progress.
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow_err  out  1  sticky: a byte was offered while not ready.

Behaviour:
- Reset (async, while rst=1):
  - uart_txd=1, to_uart_ready=0, tx_busy=0, fifo_level=0, overflow_err=0.
  - FSM goes to IDLE; pointers, bit counter and baud counter are cleared.
- After reset release: to_uart_ready=1 on the first cycle.
- Ready: to_uart_ready = (fifo_level != FIFO_DEPTH), decoded from the registered count.
- Write: the byte is accepted on any clock edge with to_uart_valid=1 and to_uart_ready=1. One byte per cycle; consecutive cycles with valid high write consecutive bytes.
- Full FIFO:
  - valid=1 with ready=0 drops the byte and sets overflow_err (cleared only by reset).
  - A pop in the same cycle does not make a write acceptable when ready=0.
- Simultaneous push and pop: level unchanged, both take effect.
- FSM states: IDLE, START, DATA, PARITY, STOP. A baud counter counts 0..CLKS_PER_BIT-1 and each bit lasts exactly CLKS_PER_BIT clocks.
  - IDLE: uart_txd=1. If FIFO non-empty: pop the head into the shift register, uart_txd<=0, go to START.
  - START: after CLKS_PER_BIT cycles, drive D0 and go to DATA.
  - DATA: LSB first; bit counter 0..7. After D7, go to PARITY if PARITY_EN, else STOP.
  - PARITY: drive XOR(data) ^ PARITY_ODD for one bit time, then STOP.
  - STOP: uart_txd=1 for one bit time. On its last cycle, if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Latency: a write into an empty FIFO with FSM in IDLE at edge N gives uart_txd low from edge N+1.
- Frame length: (10 + PARITY_EN) × CLKS_PER_BIT clocks. Back-to-back frames are contiguous.
- tx_busy = (state != IDLE) | (fifo_level != 0), registered.
- Reset mid-frame aborts the frame: uart_txd returns high immediately, FIFO contents are discarded, nothing resumes after release.
- Pointers wrap modulo FIFO_DEPTH; fifo_level ranges 0..FIFO_DEPTH inclusive.

Test Plan:
Bench parameters: CLK_FREQ=1000000, BAUD=100000 (CLKS_PER_BIT=10), FIFO_DEPTH=32 unless stated.
- Single byte: write 0xA5 at edge N → txd=0 over edges N+1..N+10, then bits 1,0,1,0,0,1,0,1 (10 clocks each), stop high 10 clocks; tx_busy falls after the stop bit; overflow_err=0.
- Burst: valid high 23 consecutive cycles with data 0x00..0x16 → all accepted, ready stays 1, peak fifo_level=22, 23 contiguous frames (2300 clocks, no idle gaps), decoded bytes 0x00..0x16 in order.
- Overflow (FIFO_DEPTH=4): valid high 6 consecutive cycles with data 0x10..0x15 → 0x10..0x14 accepted (first popped at edge 1), ready=0 on the 6th cycle, 0x15 dropped, overflow_err=1 and stays 1 after all frames finish.
- Parity: PARITY_EN=1, PARITY_ODD=0, send 0x07 → parity bit 1, frame 110 clocks. With PARITY_ODD=1 the same byte → parity bit 0.
- Reset mid-frame: pulse rst during D3 of 0x3C with 2 bytes queued → txd=1 asynchronously, fifo_level=0, no further frames. A later write of 0x81 yields one clean frame.
- Write at stop end: FIFO empty, write 0x55 on the last cycle of a STOP bit → FSM passes through IDLE for one cycle, then START; frame 0x55 decoded correctly.
